// File: rtl/zap_cache_tag_ram_gen.sv
// Cache line, tag and PA store with valid/dirty tracking and a
// Wishbone write-back engine for global and single-line cleaning.
module zap_cache_tag_ram_gen #(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_BYTES = 16,
    parameter int TAG_WDT    = 21
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [31:0]                     i_address_nxt,
    input  logic [31:0]                     i_address,
    input  logic                            i_cache_en,
    input  logic [LINE_BYTES*8-1:0]         i_cache_line,
    input  logic [LINE_BYTES-1:0]           i_cache_line_ben,
    output logic [LINE_BYTES*8-1:0]         o_cache_line,
    input  logic                            i_cache_tag_wr_en,
    input  logic [TAG_WDT-1:0]              i_cache_tag,
    input  logic                            i_cache_tag_dirty,
    input  logic [31-$clog2(LINE_BYTES):0]  i_cache_pa,
    output logic [TAG_WDT-1:0]              o_cache_tag,
    output logic [31-$clog2(LINE_BYTES):0]  o_cache_pa,
    output logic                            o_cache_tag_valid,
    output logic                            o_cache_tag_dirty,
    input  logic                            i_cache_clean_req,
    output logic                            o_cache_clean_done,
    input  logic                            i_line_clean_req,
    output logic                            o_line_clean_done,
    input  logic                            i_cache_inv_req,
    output logic                            o_cache_inv_done,
    output logic                            o_wb_cyc_nxt,
    output logic                            o_wb_stb_nxt,
    output logic                            o_wb_wen_nxt,
    output logic [31:0]                     o_wb_adr_nxt,
    output logic [31:0]                     o_wb_dat_nxt,
    output logic [3:0]                      o_wb_sel_nxt,
    output logic [2:0]                      o_wb_cti_nxt,
    output logic                            o_wb_cyc_ff,
    output logic                            o_wb_stb_ff,
    output logic                            o_wb_wen_ff,
    output logic [31:0]                     o_wb_adr_ff,
    output logic [31:0]                     o_wb_dat_ff,
    output logic [3:0]                      o_wb_sel_ff,
    output logic [2:0]                      o_wb_cti_ff,
    input  logic                            i_wb_ack,
    input  logic [31:0]                     i_wb_dat
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINES  = CACHE_SIZE / LINE_BYTES;
    localparam int IDX_W  = $clog2(LINES);
    localparam int BEATS  = LINE_BYTES / 4;
    localparam int BCNT_W = $clog2(BEATS + 1);
    localparam int PA_W   = 32 - OFF_W;
    localparam int LINE_W = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH,
        S_WRITE,
        S_INV
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BCNT_W-1:0]   beat_q, beat_d;
    logic                mode_q, mode_d;
    logic [LINES-1:0]    valid_q, dirty_q;

    logic [LINE_W-1:0]   data_mem [LINES];
    logic [TAG_WDT-1:0]  tag_mem  [LINES];
    logic [PA_W-1:0]     pa_mem   [LINES];

    logic [IDX_W-1:0]    wr_idx, nxt_idx, rd_idx, pe_idx;
    logic                pe_found, any_req, tag_we;
    logic                adv, last_beat, line_hit;
    logic                clr_dirty, inv_all;
    logic [BCNT_W-1:0]   cur_beat;

    assign wr_idx    = i_address[OFF_W+IDX_W-1:OFF_W];
    assign nxt_idx   = i_address_nxt[OFF_W+IDX_W-1:OFF_W];
    assign rd_idx    = (state_q == S_IDLE) ? nxt_idx : idx_q;
    assign any_req   = i_cache_clean_req | i_line_clean_req | i_cache_inv_req;
    assign tag_we    = (state_q == S_IDLE) & i_cache_tag_wr_en & ~any_req;
    assign adv       = i_wb_ack & o_wb_stb_ff;
    assign last_beat = adv && (beat_q == BCNT_W'(BEATS - 1));
    assign line_hit  = valid_q[idx_q] & dirty_q[idx_q];
    assign cur_beat  = beat_q + BCNT_W'(adv);

    logic unused_ok;
    assign unused_ok = ^{i_wb_dat,
                         i_address[31:OFF_W+IDX_W],
                         i_address[OFF_W-1:0],
                         i_address_nxt[31:OFF_W+IDX_W],
                         i_address_nxt[OFF_W-1:0]};

    // Lowest-numbered dirty line across the whole cache
    always_comb begin
        pe_found = 1'b0;
        pe_idx   = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                pe_found = 1'b1;
                pe_idx   = IDX_W'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state plus clean-engine index, beat count and mode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_cache_clean_req) begin
                    state_d = S_SCAN;
                    mode_d  = 1'b0;
                end else if (i_line_clean_req) begin
                    state_d = S_SCAN;
                    mode_d  = 1'b1;
                    idx_d   = wr_idx;
                end else if (i_cache_inv_req) begin
                    state_d = S_INV;
                end
            end
            S_SCAN: begin
                if (mode_q) begin
                    state_d = line_hit ? S_FETCH : S_IDLE;
                end else if (pe_found) begin
                    state_d = S_FETCH;
                    idx_d   = pe_idx;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                beat_d  = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (last_beat) begin
                    beat_d  = '0;
                    state_d = mode_q ? S_IDLE : S_SCAN;
                end else if (adv) begin
                    beat_d = beat_q + BCNT_W'(1);
                end
            end
            S_INV: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Done pulses, store side effects and next-cycle Wishbone drive
    always_comb begin
        o_cache_clean_done = 1'b0;
        o_line_clean_done  = 1'b0;
        o_cache_inv_done   = 1'b0;
        clr_dirty          = 1'b0;
        inv_all            = 1'b0;
        o_wb_cyc_nxt       = 1'b0;
        o_wb_stb_nxt       = 1'b0;
        o_wb_wen_nxt       = 1'b0;
        o_wb_adr_nxt       = '0;
        o_wb_dat_nxt       = '0;
        o_wb_sel_nxt       = '0;
        o_wb_cti_nxt       = 3'b000;
        unique case (state_q)
            S_SCAN: begin
                if (mode_q) o_line_clean_done  = ~line_hit;
                else        o_cache_clean_done = ~pe_found;
            end
            S_WRITE: begin
                clr_dirty         = last_beat;
                o_line_clean_done = last_beat & mode_q;
                if (!last_beat) begin
                    o_wb_cyc_nxt = 1'b1;
                    o_wb_stb_nxt = 1'b1;
                    o_wb_wen_nxt = 1'b1;
                    o_wb_sel_nxt = 4'hF;
                    o_wb_adr_nxt = {o_cache_pa, {OFF_W{1'b0}}}
                                 + 32'({cur_beat, 2'b00});
                    o_wb_cti_nxt = (cur_beat == BCNT_W'(BEATS - 1))
                                 ? 3'b111 : 3'b010;
                    for (int k = 0; k < BEATS; k++) begin
                        if (cur_beat == BCNT_W'(k))
                            o_wb_dat_nxt = o_cache_line[32*k +: 32];
                    end
                end
            end
            S_INV: begin
                inv_all          = 1'b1;
                o_cache_inv_done = 1'b1;
            end
            default: ;
        endcase
        if (i_reset) begin
            o_cache_clean_done = 1'b0;
            o_line_clean_done  = 1'b0;
            o_cache_inv_done   = 1'b0;
        end
    end

    // Clean-engine index, beat counter and global/line mode
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx_q  <= '0;
            beat_q <= '0;
            mode_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            beat_q <= beat_d;
            mode_q <= mode_d;
        end
    end

    // Valid and dirty bit vectors
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (tag_we) begin
                valid_q[wr_idx] <= 1'b1;
                dirty_q[wr_idx] <= i_cache_tag_dirty;
            end
            if (clr_dirty) dirty_q[idx_q] <= 1'b0;
            if (inv_all) begin
                valid_q <= '0;
                dirty_q <= '0;
            end
            if (!i_cache_en) valid_q <= '0;
        end
    end

    // Registered valid/dirty read of the current read index
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cache_tag_valid <= 1'b0;
            o_cache_tag_dirty <= 1'b0;
        end else begin
            o_cache_tag_valid <= valid_q[rd_idx];
            o_cache_tag_dirty <= dirty_q[rd_idx];
        end
    end

    // Line, tag and PA storage with synchronous read (never reset)
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (i_cache_line_ben[b])
                data_mem[wr_idx][8*b +: 8] <= i_cache_line[8*b +: 8];
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= i_cache_tag;
            pa_mem[wr_idx]  <= i_cache_pa;
        end
        o_cache_line <= data_mem[rd_idx];
        o_cache_tag  <= tag_mem[rd_idx];
        o_cache_pa   <= pa_mem[rd_idx];
    end

    // Wishbone outputs delayed by one cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc_ff <= 1'b0;
            o_wb_stb_ff <= 1'b0;
            o_wb_wen_ff <= 1'b0;
            o_wb_adr_ff <= '0;
            o_wb_dat_ff <= '0;
            o_wb_sel_ff <= '0;
            o_wb_cti_ff <= 3'b000;
        end else begin
            o_wb_cyc_ff <= o_wb_cyc_nxt;
            o_wb_stb_ff <= o_wb_stb_nxt;
            o_wb_wen_ff <= o_wb_wen_nxt;
            o_wb_adr_ff <= o_wb_adr_nxt;
            o_wb_dat_ff <= o_wb_dat_nxt;
            o_wb_sel_ff <= o_wb_sel_nxt;
            o_wb_cti_ff <= o_wb_cti_nxt;
        end
    end

endmodule

// File: tb/tb_zap_cache_tag_ram_gen.sv
// Bench for zap_cache_tag_ram_gen: scoreboarded write-back bursts,
// line clean, invalidate, cache disable and reset abort.
module tb_zap_cache_tag_ram_gen;

    localparam int TW = 21;
    localparam int PW = 28;
    localparam int LW = 128;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    beat_t exp_q[$];
    int total = 0;
    int bad   = 0;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [31:0]   i_address_nxt, i_address;
    logic          i_cache_en;
    logic [LW-1:0] i_cache_line, o_cache_line;
    logic [15:0]   i_cache_line_ben;
    logic          i_cache_tag_wr_en;
    logic [TW-1:0] i_cache_tag, o_cache_tag;
    logic          i_cache_tag_dirty;
    logic [PW-1:0] i_cache_pa, o_cache_pa;
    logic          o_cache_tag_valid, o_cache_tag_dirty;
    logic          i_cache_clean_req, o_cache_clean_done;
    logic          i_line_clean_req, o_line_clean_done;
    logic          i_cache_inv_req, o_cache_inv_done;
    logic          cyc_n, stb_n, wen_n, cyc_f, stb_f, wen_f;
    logic [31:0]   adr_n, dat_n, adr_f, dat_f;
    logic [3:0]    sel_n, sel_f;
    logic [2:0]    cti_n, cti_f;
    logic          i_wb_ack;
    logic [31:0]   i_wb_dat;

    always #5 clk = ~clk;

    zap_cache_tag_ram_gen dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_address_nxt      (i_address_nxt),
        .i_address          (i_address),
        .i_cache_en         (i_cache_en),
        .i_cache_line       (i_cache_line),
        .i_cache_line_ben   (i_cache_line_ben),
        .o_cache_line       (o_cache_line),
        .i_cache_tag_wr_en  (i_cache_tag_wr_en),
        .i_cache_tag        (i_cache_tag),
        .i_cache_tag_dirty  (i_cache_tag_dirty),
        .i_cache_pa         (i_cache_pa),
        .o_cache_tag        (o_cache_tag),
        .o_cache_pa         (o_cache_pa),
        .o_cache_tag_valid  (o_cache_tag_valid),
        .o_cache_tag_dirty  (o_cache_tag_dirty),
        .i_cache_clean_req  (i_cache_clean_req),
        .o_cache_clean_done (o_cache_clean_done),
        .i_line_clean_req   (i_line_clean_req),
        .o_line_clean_done  (o_line_clean_done),
        .i_cache_inv_req    (i_cache_inv_req),
        .o_cache_inv_done   (o_cache_inv_done),
        .o_wb_cyc_nxt       (cyc_n),
        .o_wb_stb_nxt       (stb_n),
        .o_wb_wen_nxt       (wen_n),
        .o_wb_adr_nxt       (adr_n),
        .o_wb_dat_nxt       (dat_n),
        .o_wb_sel_nxt       (sel_n),
        .o_wb_cti_nxt       (cti_n),
        .o_wb_cyc_ff        (cyc_f),
        .o_wb_stb_ff        (stb_f),
        .o_wb_wen_ff        (wen_f),
        .o_wb_adr_ff        (adr_f),
        .o_wb_dat_ff        (dat_f),
        .o_wb_sel_ff        (sel_f),
        .o_wb_cti_ff        (cti_f),
        .i_wb_ack           (i_wb_ack),
        .i_wb_dat           (i_wb_dat)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_line(input int idx, input logic [TW-1:0] tag,
                              input logic [PW-1:0] pa, input logic dirty,
                              input logic [LW-1:0] data);
        i_address         = 32'(idx) << 4;
        i_cache_line      = data;
        i_cache_line_ben  = 16'hFFFF;
        i_cache_tag_wr_en = 1'b1;
        i_cache_tag       = tag;
        i_cache_pa        = pa;
        i_cache_tag_dirty = dirty;
        tick();
        i_cache_line_ben  = 16'h0000;
        i_cache_tag_wr_en = 1'b0;
    endtask

    task automatic read_line(input int idx);
        i_address_nxt = 32'(idx) << 4;
        tick();
    endtask

    task automatic push_line(input logic [PW-1:0] pa, input logic [LW-1:0] data);
        beat_t e;
        for (int k = 0; k < 4; k++) begin
            e.adr = {pa, 4'h0} + 32'(4 * k);
            e.dat = data[32*k +: 32];
            e.cti = (k == 3) ? 3'b111 : 3'b010;
            exp_q.push_back(e);
        end
    endtask

    // Wishbone slave: acks after lat wait cycles, pops the scoreboard
    task automatic serve_bus(input int lat, input int limit,
                             output int n_clean, output int n_line,
                             output int n_inv, output int first_done);
        int waitc;
        beat_t e;
        n_clean = 0;
        n_line = 0;
        n_inv = 0;
        first_done = -1;
        waitc = 0;
        for (int c = 0; c < limit; c++) begin
            if (stb_f) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_stb adr=%h", adr_f);
                    i_wb_ack = 1'b1;
                end else if (waitc >= lat) begin
                    e = exp_q.pop_front();
                    total++;
                    if (adr_f !== e.adr || dat_f !== e.dat || cti_f !== e.cti ||
                        sel_f !== 4'hF || wen_f !== 1'b1 || cyc_f !== 1'b1) begin
                        bad++;
                        $display("FAIL beat got adr=%h dat=%h cti=%b sel=%h wen=%b cyc=%b want adr=%h dat=%h cti=%b",
                                 adr_f, dat_f, cti_f, sel_f, wen_f, cyc_f, e.adr, e.dat, e.cti);
                    end
                    i_wb_ack = 1'b1;
                    waitc = 0;
                end else begin
                    total++;
                    if (adr_f !== exp_q[0].adr) begin
                        bad++;
                        $display("FAIL wait_hold got adr=%h want %h", adr_f, exp_q[0].adr);
                    end
                    i_wb_ack = 1'b0;
                    waitc++;
                end
            end else begin
                i_wb_ack = 1'b0;
            end
            #1;
            if (o_cache_clean_done) n_clean++;
            if (o_line_clean_done) n_line++;
            if (o_cache_inv_done) n_inv++;
            if (first_done < 0 &&
                (o_cache_clean_done | o_line_clean_done | o_cache_inv_done))
                first_done = c;
            if (first_done >= 0 && c == first_done + 1) begin
                total++;
                if ({cyc_f, stb_f, wen_f, adr_f, dat_f, sel_f, cti_f} !== '0) begin
                    bad++;
                    $display("FAIL bus_idle_after cyc=%b adr=%h dat=%h sel=%h cti=%b want all 0",
                             cyc_f, adr_f, dat_f, sel_f, cti_f);
                end
            end
            if (first_done >= 0 && c == first_done + 2) break;
            tick();
        end
        i_wb_ack = 1'b0;
        if (first_done < 0) begin
            total++;
            bad++;
            $display("FAIL serve_timeout got no done pulse want one within %0d", limit);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({cyc_f, stb_f, wen_f, adr_f, dat_f, sel_f, cti_f} !== '0) begin
            bad++;
            $display("FAIL reset_bus got cyc=%b adr=%h cti=%b want 0", cyc_f, adr_f, cti_f);
        end
        total++;
        if ({o_cache_clean_done, o_line_clean_done, o_cache_inv_done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_done got %b want 000",
                     {o_cache_clean_done, o_line_clean_done, o_cache_inv_done});
        end
        i_reset = 1'b0;
        read_line(0);
        total++;
        if (o_cache_tag_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got %b want 0", o_cache_tag_valid);
        end
        total++;
        if (o_cache_tag_dirty !== 1'b0) begin
            bad++;
            $display("FAIL reset_dirty got %b want 0", o_cache_tag_dirty);
        end
    endtask

    task automatic test_tag_write();
        logic [LW-1:0] l3, l4;
        l3 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        write_line(3, 21'h1ABCD, 28'h0000100, 1'b1, l3);
        read_line(3);
        total++;
        if (o_cache_tag !== 21'h1ABCD || o_cache_pa !== 28'h0000100) begin
            bad++;
            $display("FAIL tag_pa got tag=%h pa=%h want 1abcd 0000100", o_cache_tag, o_cache_pa);
        end
        total++;
        if (o_cache_tag_valid !== 1'b1 || o_cache_tag_dirty !== 1'b1) begin
            bad++;
            $display("FAIL tag_vd got v=%b d=%b want 1 1", o_cache_tag_valid, o_cache_tag_dirty);
        end
        total++;
        if (o_cache_line !== l3) begin
            bad++;
            $display("FAIL line_data got %h want %h", o_cache_line, l3);
        end
        i_address        = 32'h40;
        i_cache_line     = {4{32'h55555555}};
        i_cache_line_ben = 16'hFFFF;
        tick();
        i_cache_line     = {4{32'hAAAAAAAA}};
        i_cache_line_ben = 16'h000F;
        tick();
        i_cache_line_ben = 16'h0000;
        read_line(4);
        l4 = {32'h55555555, 32'h55555555, 32'h55555555, 32'hAAAAAAAA};
        total++;
        if (o_cache_line !== l4 || o_cache_tag_valid !== 1'b0) begin
            bad++;
            $display("FAIL byte_enable got %h v=%b want %h v=0", o_cache_line, o_cache_tag_valid, l4);
        end
    endtask

    task automatic test_global_clean();
        int nc, nl, ni, fd;
        push_line(28'h0000100, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        i_cache_clean_req = 1'b1;
        tick();
        i_cache_clean_req = 1'b0;
        serve_bus(0, 60, nc, nl, ni, fd);
        total++;
        if (nc != 1 || nl != 0 || ni != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL gclean_done got clean=%0d line=%0d inv=%0d left=%0d want 1 0 0 0",
                     nc, nl, ni, exp_q.size());
        end
        exp_q.delete();
        read_line(3);
        total++;
        if (o_cache_tag_dirty !== 1'b0 || o_cache_tag_valid !== 1'b1) begin
            bad++;
            $display("FAIL gclean_line3 got d=%b v=%b want d=0 v=1", o_cache_tag_dirty, o_cache_tag_valid);
        end
    endtask

    task automatic test_back_to_back();
        int nc, nl, ni, fd;
        logic [LW-1:0] l1, l60;
        l1  = {32'h1D1D0003, 32'h1D1D0002, 32'h1D1D0001, 32'h1D1D0000};
        l60 = {32'h60600003, 32'h60600002, 32'h60600001, 32'h60600000};
        write_line(60, 21'h00060, 28'h1234500, 1'b1, l60);
        write_line(1, 21'h00001, 28'h00ABC00, 1'b1, l1);
        push_line(28'h00ABC00, l1);
        push_line(28'h1234500, l60);
        i_cache_clean_req = 1'b1;
        tick();
        i_cache_clean_req = 1'b0;
        serve_bus(2, 200, nc, nl, ni, fd);
        total++;
        if (nc != 1 || nl != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_done got clean=%0d line=%0d left=%0d want 1 0 0", nc, nl, exp_q.size());
        end
        exp_q.delete();
        read_line(1);
        total++;
        if (o_cache_tag_dirty !== 1'b0) begin
            bad++;
            $display("FAIL b2b_dirty1 got %b want 0", o_cache_tag_dirty);
        end
        read_line(60);
        total++;
        if (o_cache_tag_dirty !== 1'b0) begin
            bad++;
            $display("FAIL b2b_dirty60 got %b want 0", o_cache_tag_dirty);
        end
    endtask

    task automatic test_line_clean_clean();
        int nc, nl, ni, fd;
        i_address = 32'h30;
        i_line_clean_req = 1'b1;
        tick();
        i_line_clean_req = 1'b0;
        serve_bus(0, 20, nc, nl, ni, fd);
        total++;
        if (nl != 1 || nc != 0 || fd != 0) begin
            bad++;
            $display("FAIL lclean_clean got line=%0d clean=%0d at=%0d want 1 0 0", nl, nc, fd);
        end
    endtask

    task automatic test_line_clean_dirty();
        int nc, nl, ni, fd;
        logic [LW-1:0] l5;
        l5 = {32'h5A5A5A03, 32'h5A5A5A02, 32'h5A5A5A01, 32'h5A5A5A00};
        write_line(5, 21'h00005, 28'h000ABCD, 1'b1, l5);
        push_line(28'h000ABCD, l5);
        i_address = 32'h50;
        i_line_clean_req = 1'b1;
        tick();
        i_line_clean_req = 1'b0;
        serve_bus(1, 80, nc, nl, ni, fd);
        total++;
        if (nl != 1 || nc != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL lclean_dirty got line=%0d clean=%0d left=%0d want 1 0 0", nl, nc, exp_q.size());
        end
        exp_q.delete();
        read_line(5);
        total++;
        if (o_cache_tag_dirty !== 1'b0 || o_cache_tag_valid !== 1'b1) begin
            bad++;
            $display("FAIL lclean_line5 got d=%b v=%b want 0 1", o_cache_tag_dirty, o_cache_tag_valid);
        end
    endtask

    task automatic test_tag_ignored();
        int nc, nl, ni, fd;
        i_address         = 32'h70;
        i_cache_tag_wr_en = 1'b1;
        i_cache_tag       = 21'h00007;
        i_cache_pa        = 28'h0000777;
        i_cache_tag_dirty = 1'b1;
        i_cache_clean_req = 1'b1;
        tick();
        i_cache_tag_wr_en = 1'b0;
        i_cache_clean_req = 1'b0;
        serve_bus(0, 20, nc, nl, ni, fd);
        total++;
        if (nc != 1 || fd != 0) begin
            bad++;
            $display("FAIL ignored_clean got clean=%0d at=%0d want 1 0", nc, fd);
        end
        read_line(7);
        total++;
        if (o_cache_tag_valid !== 1'b0) begin
            bad++;
            $display("FAIL ignored_tag got v=%b want 0", o_cache_tag_valid);
        end
    endtask

    task automatic test_cache_en();
        write_line(9, 21'h00009, 28'h0000900, 1'b1, {4{32'h99999999}});
        i_cache_en = 1'b0;
        tick();
        i_cache_en = 1'b1;
        read_line(9);
        total++;
        if (o_cache_tag_valid !== 1'b0 || o_cache_tag_dirty !== 1'b1) begin
            bad++;
            $display("FAIL cache_en_line9 got v=%b d=%b want 0 1", o_cache_tag_valid, o_cache_tag_dirty);
        end
        read_line(3);
        total++;
        if (o_cache_tag_valid !== 1'b0) begin
            bad++;
            $display("FAIL cache_en_line3 got v=%b want 0", o_cache_tag_valid);
        end
    endtask

    task automatic test_invalidate();
        int nc, nl, ni, fd;
        write_line(10, 21'h0000A, 28'h0000A00, 1'b0, {4{32'hA0A0A0A0}});
        write_line(11, 21'h0000B, 28'h0000B00, 1'b1, {4{32'hB0B0B0B0}});
        read_line(11);
        total++;
        if (o_cache_tag_valid !== 1'b1) begin
            bad++;
            $display("FAIL inv_pre got v=%b want 1", o_cache_tag_valid);
        end
        i_cache_inv_req = 1'b1;
        tick();
        i_cache_inv_req = 1'b0;
        serve_bus(0, 20, nc, nl, ni, fd);
        total++;
        if (ni != 1 || nc != 0 || nl != 0 || fd != 0) begin
            bad++;
            $display("FAIL inv_done got inv=%0d clean=%0d line=%0d at=%0d want 1 0 0 0", ni, nc, nl, fd);
        end
        for (int i = 0; i < 64; i++) begin
            read_line(i);
            total++;
            if (o_cache_tag_valid !== 1'b0 || o_cache_tag_dirty !== 1'b0) begin
                bad++;
                $display("FAIL inv_line%0d got v=%b d=%b want 0 0", i, o_cache_tag_valid, o_cache_tag_dirty);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int acks;
        bit hit;
        bit seen;
        acks = 0;
        hit = 1'b0;
        seen = 1'b0;
        write_line(2, 21'h00002, 28'h0000200, 1'b1, {32'h22220003, 32'h22220002, 32'h22220001, 32'h22220000});
        i_cache_clean_req = 1'b1;
        tick();
        i_cache_clean_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (stb_f) begin
                if (acks == 2) begin
                    hit = 1'b1;
                    break;
                end
                i_wb_ack = 1'b1;
                acks++;
            end else begin
                i_wb_ack = 1'b0;
            end
            tick();
        end
        i_wb_ack = 1'b0;
        total++;
        if (!hit || adr_f !== 32'h00002008) begin
            bad++;
            $display("FAIL abort_beat2 got hit=%0d adr=%h want 1 00002008", hit, adr_f);
        end
        i_reset = 1'b1;
        tick();
        total++;
        if (cyc_f !== 1'b0 || stb_f !== 1'b0) begin
            bad++;
            $display("FAIL abort_cyc got cyc=%b stb=%b want 0 0", cyc_f, stb_f);
        end
        i_reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (o_cache_clean_done | o_line_clean_done | o_cache_inv_done | cyc_f | cyc_n)
                seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_quiet got activity=1 want 0");
        end
        read_line(2);
        total++;
        if (o_cache_tag_dirty !== 1'b0 || o_cache_tag_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_line2 got d=%b v=%b want 0 0", o_cache_tag_dirty, o_cache_tag_valid);
        end
        write_line(2, 21'h00002, 28'h0000200, 1'b0, {4{32'h0}});
        read_line(2);
        total++;
        if (o_cache_tag_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle got v=%b want 1", o_cache_tag_valid);
        end
    endtask

    initial begin
        i_reset           = 1'b1;
        i_address_nxt     = '0;
        i_address         = '0;
        i_cache_en        = 1'b1;
        i_cache_line      = '0;
        i_cache_line_ben  = '0;
        i_cache_tag_wr_en = 1'b0;
        i_cache_tag       = '0;
        i_cache_tag_dirty = 1'b0;
        i_cache_pa        = '0;
        i_cache_clean_req = 1'b0;
        i_line_clean_req  = 1'b0;
        i_cache_inv_req   = 1'b0;
        i_wb_ack          = 1'b0;
        i_wb_dat          = '0;
        @(negedge clk);
        repeat (3) tick();
        test_reset();
        test_tag_write();
        test_global_clean();
        test_back_to_back();
        test_line_clean_clean();
        test_line_clean_dirty();
        test_tag_ignored();
        test_cache_en();
        test_invalidate();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
